eth_axis_tx_writer: RTL
=======================

// Module: eth_axis_tx_writer
// PURPOSE
//  Upstream feeder for the eth_rgmii AXI4 slave port. Accepts an outgoing Ethernet frame on a
//  64-bit AXI4-Stream input. Writes each beat into the MAC TX buffer as one single-beat AXI4
//  write (AW/W/B). When the frame ends, writes the frame byte count to the TX length register,
//  which launches transmission. Replaces hand-driven AXI writes from the TB/CPU for frame send.
// PARAMETERS
//  AW         32           AXI address width
//  DW         64           AXI/stream data width (bytes per beat = DW/8)
//  IW         8            AXI ID width; all transactions use ID 0
//  BUF_BASE   'h0000_0800  byte address of TX buffer beat 0
//  LEN_ADDR   'h0000_0810  byte address of TX length/kick register
//  MAX_BEATS  192          buffer depth in beats; a frame longer than this is truncated
// PORTS
//  clk_i          in   1       clock (AXI clock domain)
//  rst_ni         in   1       synchronous, active-low reset
//  s_tdata_i      in   DW      stream data, byte 0 in bits [7:0]
//  s_tkeep_i      in   DW/8    byte valid mask; contiguous from bit 0; all-ones except on last beat
//  s_tlast_i      in   1       last beat of frame
//  s_tvalid_i     in   1       stream valid
//  s_tready_o     out  1       stream ready
//  aw_addr_o      out  AW      write address
//  aw_id_o        out  IW      constant 0
//  aw_valid_o     out  1       write address valid
//  aw_ready_i     in   1       write address ready
//  w_data_o       out  DW      write data
//  w_strb_o       out  DW/8    write strobe
//  w_last_o       out  1       constant 1 (single-beat bursts; len=0, size=log2(DW/8), INCR)
//  w_valid_o      out  1       write data valid
//  w_ready_i      in   1       write data ready
//  b_resp_i       in   2       write response
//  b_valid_i      in   1       write response valid
//  b_ready_o      out  1       write response ready
//  frame_done_o   out  1       one-cycle pulse after the length write's B handshake
//  err_o          out  1       sticky; set on non-OKAY b_resp or truncation; cleared by reset only
// BEHAVIOUR
//  Reset: all valid/ready outputs 0, addr/data/strb 0, frame_done_o 0, err_o 0,
//   beat_cnt 0, byte_cnt 0, FSM=IDLE. Reset mid-transaction abandons it immediately.
//  FSM states:
//   IDLE  s_tready_o=1. On tvalid&tready, latch data/keep/last into the holding regs, then -> WR.
//   WR    aw_valid_o and w_valid_o both assert on entry. Each valid drops independently on its
//         own handshake. AW and W may complete in either order or in the same cycle. Once both
//         have completed -> RESP.
//   RESP  b_ready_o=1. On b_valid_i: if the latched last bit is 0 -> IDLE, else -> LEN_WR.
//   LEN_WR  Like WR: aw_addr=LEN_ADDR, w_data=zero-extended byte_cnt, w_strb all ones.
//   LEN_RESP  b_ready_o=1. On b_valid_i, pulse frame_done_o for 1 cycle, clear beat_cnt and
//             byte_cnt -> IDLE.
//   DROP  s_tready_o=1. Discard beats up to and including tlast, then -> LEN_WR.
//  Data beat address: BUF_BASE + beat_cnt*(DW/8). w_strb_o = latched tkeep.
//  beat_cnt and byte_cnt update on the data beat's B handshake. byte_cnt += popcount(tkeep).
//   byte_cnt is 16 bits wide.
//  Truncation: when beat_cnt reaches MAX_BEATS after a B handshake and the last bit was 0:
//   set err_o and go to DROP instead of IDLE. The length written is MAX_BEATS*(DW/8).
//  b_resp_i != 2'b00 sets err_o. Flow continues normally; no retry.
//  AXI rule: no valid deasserts before its handshake. Addr/data are stable while valid is high.
//  Throughput: 1 beat per 3 cycles minimum, when aw/w/b are ready/valid in consecutive cycles.
//  tready is low in WR/RESP/LEN_* states. The stream is back-pressured during each write.
// TESTING
//  1-beat frame, data 'hcafebabe, tkeep 'h0F, tlast -> write 'h800 strb 'h0F; length 4 to 'h810;
//   frame_done_o pulses once.
//  3-beat frame, keep FF,FF,07 -> writes to 'h800,'h808,'h810... (use LEN_ADDR 'h900);
//   length 19; frame_done_o pulses.
//  aw_ready held low 5 cycles, w_ready immediately -> W completes first. aw_valid_o and
//   aw_addr_o stay stable until aw_ready. Exactly one write per beat.
//  b_resp=SLVERR on beat 2 of 3 -> err_o=1 and stays 1. Remaining beats and the length write
//   still occur.
//  MAX_BEATS=4, 6-beat frame -> 4 buffer writes; beats 5-6 consumed without writes; length 32;
//   err_o=1.
//  rst_ni low for 1 cycle during WR -> next cycle all valids 0, FSM=IDLE.
//   A new 1-beat frame then writes at BUF_BASE.

Source files
------------

// File: rtl/eth_axis_tx_writer_if.sv
// Bundle of the stream input and the AXI4 write channels used by eth_axis_tx_writer.
// Handshake rule on every channel: a transfer happens on the rising clock edge where
// valid and ready are both high; once valid is raised it stays high, with its payload
// unchanged, until that transfer; ready may be raised or lowered freely.
interface eth_axis_tx_writer_if #(
  parameter int AW = 32,
  parameter int DW = 64,
  parameter int IW = 8
);
  // AXI4-Stream frame input
  logic [DW-1:0]   s_tdata_i;
  logic [DW/8-1:0] s_tkeep_i;
  logic            s_tlast_i;
  logic            s_tvalid_i;
  logic            s_tready_o;
  // AXI4 write address channel
  logic [AW-1:0]   aw_addr_o;
  logic [IW-1:0]   aw_id_o;
  logic            aw_valid_o;
  logic            aw_ready_i;
  // AXI4 write data channel
  logic [DW-1:0]   w_data_o;
  logic [DW/8-1:0] w_strb_o;
  logic            w_last_o;
  logic            w_valid_o;
  logic            w_ready_i;
  // AXI4 write response channel
  logic [1:0]      b_resp_i;
  logic            b_valid_i;
  logic            b_ready_o;

  // The writer: stream sink and AXI write master
  modport master (
    input  s_tdata_i, s_tkeep_i, s_tlast_i, s_tvalid_i,
    output s_tready_o,
    output aw_addr_o, aw_id_o, aw_valid_o,
    input  aw_ready_i,
    output w_data_o, w_strb_o, w_last_o, w_valid_o,
    input  w_ready_i,
    input  b_resp_i, b_valid_i,
    output b_ready_o
  );

  // The environment: stream source and AXI write slave
  modport slave (
    output s_tdata_i, s_tkeep_i, s_tlast_i, s_tvalid_i,
    input  s_tready_o,
    input  aw_addr_o, aw_id_o, aw_valid_o,
    output aw_ready_i,
    input  w_data_o, w_strb_o, w_last_o, w_valid_o,
    output w_ready_i,
    output b_resp_i, b_valid_i,
    input  b_ready_o
  );
endinterface

// File: rtl/eth_axis_tx_writer.sv
// Copies an outgoing Ethernet frame from a 64-bit stream into the MAC TX buffer, one
// single-beat AXI4 write per stream beat, then writes the frame byte count to the TX
// length register to launch transmission. Frames longer than the buffer are truncated.
// dbg_state_o encoding: 0 IDLE, 1 WR, 2 RESP, 3 LEN_WR, 4 LEN_RESP, 5 DROP.
module eth_axis_tx_writer #(
  parameter int            AW        = 32,
  parameter int            DW        = 64,
  parameter int            IW        = 8,
  parameter logic [AW-1:0] BUF_BASE  = 'h0000_0800,
  parameter logic [AW-1:0] LEN_ADDR  = 'h0000_0810,
  parameter int            MAX_BEATS = 192
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  eth_axis_tx_writer_if.master bus,
  output logic                frame_done_o,
  output logic                err_o,
  output logic [2:0]          dbg_state_o
);

  localparam int BPB = DW / 8;
  localparam int BCW = $clog2(MAX_BEATS + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RESP     = 3'd2,
    S_LEN_WR   = 3'd3,
    S_LEN_RESP = 3'd4,
    S_DROP     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   aw_addr_q, aw_addr_d;
  logic            aw_valid_q, aw_valid_d;
  logic [DW-1:0]   w_data_q, w_data_d;
  logic [BPB-1:0]  w_strb_q, w_strb_d;
  logic            w_valid_q, w_valid_d;
  logic [BPB-1:0]  keep_q, keep_d;
  logic            last_q, last_d;
  logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0]     byte_cnt_q, byte_cnt_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  // Holds tready low for the first cycle after reset so every ready is 0 in reset
  logic            rdy_en_q, rdy_en_d;

  logic            s_ready;
  logic            b_ready;
  logic            aw_hs, w_hs, b_hs, s_hs;
  logic [BCW-1:0]  beat_next;
  logic [15:0]     byte_next;
  logic            len_go;
  logic [15:0]     len_val;

  function automatic logic [15:0] popcount(input logic [BPB-1:0] k);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < BPB; i++) c = c + 16'(k[i]);
    return c;
  endfunction

  // Next-state, channel valids, payload registers and frame counters
  always_comb begin
    state_d    = state_q;
    aw_addr_d  = aw_addr_q;
    aw_valid_d = aw_valid_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    w_valid_d  = w_valid_q;
    keep_d     = keep_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    byte_cnt_d = byte_cnt_q;
    err_d      = err_q;
    done_d     = 1'b0;
    rdy_en_d   = 1'b1;
    len_go     = 1'b0;
    len_val    = '0;

    s_ready   = rdy_en_q && (state_q == S_IDLE || state_q == S_DROP);
    b_ready   = (state_q == S_RESP || state_q == S_LEN_RESP);
    s_hs      = bus.s_tvalid_i && s_ready;
    aw_hs     = aw_valid_q && bus.aw_ready_i;
    w_hs      = w_valid_q && bus.w_ready_i;
    b_hs      = bus.b_valid_i && b_ready;
    beat_next = beat_cnt_q + BCW'(1);
    byte_next = byte_cnt_q + popcount(keep_q);

    case (state_q)
      S_IDLE: begin
        if (s_hs) begin
          keep_d     = bus.s_tkeep_i;
          last_d     = bus.s_tlast_i;
          aw_addr_d  = BUF_BASE + AW'(beat_cnt_q) * AW'(BPB);
          w_data_d   = bus.s_tdata_i;
          w_strb_d   = bus.s_tkeep_i;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          state_d    = S_WR;
        end
      end
      S_WR, S_LEN_WR: begin
        // AW and W finish independently; leave once neither is still outstanding
        if (aw_hs) aw_valid_d = 1'b0;
        if (w_hs)  w_valid_d  = 1'b0;
        if ((!aw_valid_q || aw_hs) && (!w_valid_q || w_hs))
          state_d = (state_q == S_WR) ? S_RESP : S_LEN_RESP;
      end
      S_RESP: begin
        if (b_hs) begin
          beat_cnt_d = beat_next;
          byte_cnt_d = byte_next;
          if (bus.b_resp_i != 2'b00) err_d = 1'b1;
          if (last_q) begin
            len_go  = 1'b1;
            len_val = byte_next;
          end else if (beat_next == BCW'(MAX_BEATS)) begin
            // Buffer full with more frame to come: flag it and swallow the rest
            err_d   = 1'b1;
            state_d = S_DROP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_LEN_RESP: begin
        if (b_hs) begin
          if (bus.b_resp_i != 2'b00) err_d = 1'b1;
          done_d     = 1'b1;
          beat_cnt_d = '0;
          byte_cnt_d = '0;
          state_d    = S_IDLE;
        end
      end
      S_DROP: begin
        if (s_hs && bus.s_tlast_i) begin
          len_go  = 1'b1;
          len_val = byte_cnt_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Length/kick write shared by normal frame end and the end of a dropped tail
    if (len_go) begin
      aw_addr_d  = LEN_ADDR;
      w_data_d   = DW'(len_val);
      w_strb_d   = '1;
      aw_valid_d = 1'b1;
      w_valid_d  = 1'b1;
      state_d    = S_LEN_WR;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      aw_addr_q  <= '0;
      aw_valid_q <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      w_valid_q  <= 1'b0;
      keep_q     <= '0;
      last_q     <= 1'b0;
      beat_cnt_q <= '0;
      byte_cnt_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      aw_addr_q  <= aw_addr_d;
      aw_valid_q <= aw_valid_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      w_valid_q  <= w_valid_d;
      keep_q     <= keep_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      rdy_en_q   <= rdy_en_d;
    end
  end

  assign bus.s_tready_o = s_ready;
  assign bus.aw_addr_o  = aw_addr_q;
  assign bus.aw_id_o    = IW'(0);
  assign bus.aw_valid_o = aw_valid_q;
  assign bus.w_data_o   = w_data_q;
  assign bus.w_strb_o   = w_strb_q;
  assign bus.w_last_o   = 1'b1;
  assign bus.w_valid_o  = w_valid_q;
  assign bus.b_ready_o  = b_ready;
  assign frame_done_o   = done_q;
  assign err_o          = err_q;
  assign dbg_state_o    = state_q;

endmodule
